// File: rtl/r5p_ifq.sv
// ============================================================================
// r5p_ifq -- instruction fetch queue
// ----------------------------------------------------------------------------
// Sits between the core instruction fetch port (if_*) and a pipelined
// instruction memory (mem_*). Sequential words are prefetched into a
// DEPTH-entry FIFO so straight-line code is served one word per cycle.
// A fetch address that does not match the head of the stream clears the
// FIFO, drops every response still in flight for the old stream and
// restarts prefetching at the new address.
//
// Parameters
//   IAW    address width (core and memory side)
//   IDW    instruction width; the sequential address step is IDW/8
//   IBW    byte count of if_rdt / mem_rdt
//   DEPTH  FIFO entries and max outstanding memory requests (power of 2, >=2)
//
// Ports
//   clk       clock
//   rst       asynchronous active-high reset
//   if_vld    core fetch request
//   if_adr    core fetch address
//   if_rdt    instruction, valid the cycle after an if_vld & if_rdy handshake
//   if_rdy    fetch accepted this cycle (head hit)
//   mem_req   memory read request
//   mem_adr   memory read address
//   mem_ack   memory accepted the request this cycle
//   mem_rvl   memory response valid (responses return in request order)
//   mem_rdt   memory response data
//   stat_hit  handshake counter  (only with R5P_IFQ_STAT_EN)
//   stat_fls  flush counter      (only with R5P_IFQ_STAT_EN)
//
// Build option
//   R5P_IFQ_STAT_EN  when defined, adds the stat_hit / stat_fls counters and
//                    ports. All other behaviour is the same either way.
// ============================================================================
module r5p_ifq #(
    parameter int unsigned IAW   = 32,
    parameter int unsigned IDW   = 32,
    parameter int unsigned IBW   = IDW/8,
    parameter int unsigned DEPTH = 4
)(
    input  logic               clk,
    input  logic               rst,
    // core fetch port
    input  logic               if_vld,
    input  logic [IAW-1:0]     if_adr,
    output logic [IBW*8-1:0]   if_rdt,
    output logic               if_rdy,
    // memory port
    output logic               mem_req,
    output logic [IAW-1:0]     mem_adr,
    input  logic               mem_ack,
    input  logic               mem_rvl,
    input  logic [IBW*8-1:0]   mem_rdt
`ifdef R5P_IFQ_STAT_EN
    ,
    output logic [31:0]        stat_hit,
    output logic [31:0]        stat_fls
`endif
);

    // pointer index width and counter width (counters must reach DEPTH)
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [IAW-1:0] STEP    = IAW'(IDW/8);
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    // ------------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [IAW-1:0]     hadr_q,  hadr_d;   // address of the oldest word of the stream
    logic [IAW-1:0]     pfa_q,   pfa_d;    // next prefetch address
    logic [CW-1:0]      out_q,   out_d;    // requests in flight
    logic [CW-1:0]      dsc_q,   dsc_d;    // responses still to be discarded
    logic [CW-1:0]      wptr_q,  wptr_d;   // FIFO pointers carry one wrap bit
    logic [CW-1:0]      rptr_q,  rptr_d;
    logic [IBW*8-1:0]   rdt_q,   rdt_d;

    // FIFO storage; read out through rdt_q, so no reset is needed here
    logic [IBW*8-1:0]   fifo_mem [DEPTH];

    // ------------------------------------------------------------------------
    // decode of the current cycle
    // ------------------------------------------------------------------------
    logic [CW-1:0]      occ;
    logic [CW:0]        fill;
    logic               fifo_empty;
    logic               active;
    logic               hit;
    logic               miss;
    logic               acc;
    logic               push;

    assign occ        = wptr_q - rptr_q;
    assign fill       = {1'b0, occ} + {1'b0, out_q};
    assign fifo_empty = (occ == '0);
    assign active     = (state_q != ST_IDLE);

    // The FIFO is only ever non-empty in RUN, so a hit implies RUN.
    assign hit  = active && if_vld && !fifo_empty && (if_adr == hadr_q);
    assign miss = active && if_vld && (if_adr != hadr_q);

    // Requests are capped by occupancy + in-flight, so a response always
    // finds a free FIFO slot.
    assign mem_req = (state_q == ST_RUN) && (fill < DEPTH_C);
    assign acc     = mem_req && mem_ack;

    // A response that lands in the same cycle as a miss belongs to the old
    // stream and is dropped.
    assign push = (state_q == ST_RUN) && mem_rvl && !miss;

    assign if_rdy  = hit;
    assign if_rdt  = rdt_q;
    assign mem_adr = pfa_q;

    // ------------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hadr_d  = hadr_q;
        pfa_d   = pfa_q;
        out_d   = out_q;
        dsc_d   = dsc_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdt_d   = rdt_q;

        if (state_q == ST_IDLE) begin
            // first fetch only seeds the stream; no handshake this cycle
            if (if_vld) begin
                state_d = ST_RUN;
                hadr_d  = if_adr;
                pfa_d   = if_adr;
            end
        end else begin
            out_d = out_q + CW'(acc) - CW'(mem_rvl);

            if (acc) begin
                pfa_d = pfa_q + STEP;
            end

            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end

            if (hit) begin
                rptr_d = rptr_q + 1'b1;
                hadr_d = hadr_q + STEP;
                rdt_d  = fifo_mem[rptr_q[PW-1:0]];
            end

            if (state_q == ST_DRAIN) begin
                if (mem_rvl) begin
                    dsc_d = dsc_q - 1'b1;
                end
                if (dsc_d == '0) begin
                    state_d = ST_RUN;
                end
            end

            // A miss overrides everything above except the in-flight count.
            // Every request still outstanding after this edge (including one
            // acked right now) was issued for the old stream.
            if (miss) begin
                wptr_d  = '0;
                rptr_d  = '0;
                hadr_d  = if_adr;
                pfa_d   = if_adr;
                dsc_d   = out_d;
                state_d = (out_d != '0) ? ST_DRAIN : ST_RUN;
            end
        end
    end

    // ------------------------------------------------------------------------
    // registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hadr_q  <= '0;
            pfa_q   <= '0;
            out_q   <= '0;
            dsc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdt_q   <= '0;
        end else begin
            state_q <= state_d;
            hadr_q  <= hadr_d;
            pfa_q   <= pfa_d;
            out_q   <= out_d;
            dsc_q   <= dsc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdt_q   <= rdt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q[PW-1:0]] <= mem_rdt;
        end
    end

`ifdef R5P_IFQ_STAT_EN
    // ------------------------------------------------------------------------
    // statistics
    // ------------------------------------------------------------------------
    logic [31:0] stat_hit_q, stat_hit_d;
    logic [31:0] stat_fls_q, stat_fls_d;

    always_comb begin
        stat_hit_d = stat_hit_q + 32'(hit);
        stat_fls_d = stat_fls_q + 32'(miss);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hit_q <= '0;
            stat_fls_q <= '0;
        end else begin
            stat_hit_q <= stat_hit_d;
            stat_fls_q <= stat_fls_d;
        end
    end

    assign stat_hit = stat_hit_q;
    assign stat_fls = stat_fls_q;
`endif

endmodule
